// File: rtl/clk_div_ctrl_if.sv
// Handshake and status bundle for clk_div_ctrl; retarget_cnt exists only when
// CLK_DIV_CTRL_STATS_EN is defined.
interface clk_div_ctrl_if;
    logic       ena;
    logic       run;
    logic       cfg_valid;
    logic [1:0] cfg_sel;
    logic       cfg_ready;
    logic       div_out;
    logic       tick;
    logic       busy;
    logic [1:0] cur_sel;
`ifdef CLK_DIV_CTRL_STATS_EN
    logic [7:0] retarget_cnt;
`endif

    modport master (
        output ena, run, cfg_valid, cfg_sel,
`ifdef CLK_DIV_CTRL_STATS_EN
        input  retarget_cnt,
`endif
        input  cfg_ready, div_out, tick, busy, cur_sel
    );

    modport slave (
        input  ena, run, cfg_valid, cfg_sel,
`ifdef CLK_DIV_CTRL_STATS_EN
        output retarget_cnt,
`endif
        output cfg_ready, div_out, tick, busy, cur_sel
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider (/2../16) with retarget-at-boundary handshake.
// Define CLK_DIV_CTRL_STATS_EN to add the saturating retarget_cnt counter.
module clk_div_ctrl #(
    parameter logic [1:0] DEFAULT_SEL = 2'd0
) (
    input logic           clk,
    input logic           rst_n,
    clk_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StPend, StStop} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cur_sel_q, cur_sel_d;
    logic [1:0] pend_sel_q, pend_sel_d;
    logic       pend_q, pend_d;
    logic       wrap_bits;
    logic       boundary;
    logic       cfg_ready;
    logic       accept;
    logic       apply;

    // Last cycle of a div_out period: low cur_sel+1 bits of cnt all ones.
    always_comb begin
        case (cur_sel_q)
            2'd0:    wrap_bits = cnt_q[0];
            2'd1:    wrap_bits = &cnt_q[1:0];
            2'd2:    wrap_bits = &cnt_q[2:0];
            default: wrap_bits = &cnt_q;
        endcase
    end

    assign boundary  = wrap_bits && (state_q != StIdle);
    assign cfg_ready = bus.ena && ((state_q == StIdle) || ((state_q == StRun) && bus.run));
    assign accept    = bus.cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        pend_d     = pend_q;
        apply      = 1'b0;
        if (bus.ena) begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = 4'd0;
                    if (accept) cur_sel_d = bus.cfg_sel;
                    if (bus.run) state_d = StRun;
                end
                StRun: begin
                    cnt_d = cnt_q + 4'd1;
                    if (!bus.run) begin
                        state_d = StStop;
                    end else if (accept) begin
                        pend_sel_d = bus.cfg_sel;
                        pend_d     = 1'b1;
                        state_d    = StPend;
                    end
                end
                StPend: begin
                    cnt_d = cnt_q + 4'd1;
                    // Dropping run wins; the pending select is kept for STOP to apply.
                    if (!bus.run) begin
                        state_d = StStop;
                    end else if (boundary) begin
                        cur_sel_d = pend_sel_q;
                        pend_d    = 1'b0;
                        apply     = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = StRun;
                    end
                end
                StStop: begin
                    cnt_d = cnt_q + 4'd1;
                    if (boundary) begin
                        if (pend_q) begin
                            cur_sel_d = pend_sel_q;
                            pend_d    = 1'b0;
                            apply     = 1'b1;
                        end
                        cnt_d   = 4'd0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cur_sel_q  <= DEFAULT_SEL;
            pend_sel_q <= 2'd0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.div_out   = (state_q != StIdle) && cnt_q[cur_sel_q];
    assign bus.tick      = boundary && bus.ena;
    assign bus.busy      = (state_q != StIdle);
    assign bus.cur_sel   = cur_sel_q;

`ifdef CLK_DIV_CTRL_STATS_EN
    logic [7:0] retarget_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retarget_q <= 8'd0;
        end else if (apply && (retarget_q != 8'hff)) begin
            retarget_q <= retarget_q + 8'd1;
        end
    end

    assign bus.retarget_cnt = retarget_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed-vector bench for clk_div_ctrl; expected outputs are queued per cycle and
// checked by an independent monitor on the falling edge.
module tb_clk_div_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc_n = 0;
    int   total = 0;
    int   bad = 0;

    clk_div_ctrl_if bus ();

    clk_div_ctrl #(.DEFAULT_SEL(2'd0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // exp packs {div_out, tick, busy, cfg_ready, cur_sel}
    typedef struct {
        int         id;
        string      nm;
        logic [5:0] exp;
    } chk_t;
    chk_t sb[$];

`ifdef CLK_DIV_CTRL_STATS_EN
    typedef struct {
        int         id;
        logic [7:0] val;
    } rc_t;
    rc_t rc_q[$];

    task automatic rc_exp(input logic [7:0] v);
        rc_t r;
        r.id  = cyc_n;
        r.val = v;
        rc_q.push_back(r);
    endtask
`endif

    function automatic logic [5:0] ex(input logic d, input logic t, input logic b,
                                      input logic r, input logic [1:0] s);
        return {d, t, b, r, s};
    endfunction

    task automatic cyc(input logic r, input logic e, input logic ru, input logic v,
                       input logic [1:0] s, input logic c, input string nm,
                       input logic [5:0] x);
        chk_t k;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.ena       = e;
        bus.run       = ru;
        bus.cfg_valid = v;
        bus.cfg_sel   = s;
        if (c) begin
            k.id  = cyc_n;
            k.nm  = nm;
            k.exp = x;
            sb.push_back(k);
        end
    endtask

    always @(negedge clk) begin
        chk_t       k;
        logic [5:0] act;
        if (sb.size() > 0 && sb[0].id == cyc_n) begin
            k   = sb.pop_front();
            act = {bus.div_out, bus.tick, bus.busy, bus.cfg_ready, bus.cur_sel};
            total++;
            if (act !== k.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got {div,tick,busy,rdy,sel}=%b want=%b",
                         k.nm, cyc_n, act, k.exp);
            end
        end
`ifdef CLK_DIV_CTRL_STATS_EN
        if (rc_q.size() > 0 && rc_q[0].id == cyc_n) begin
            rc_t r;
            r = rc_q.pop_front();
            total++;
            if (bus.retarget_cnt !== r.val) begin
                bad++;
                $display("FAIL retarget_cnt cyc=%0d got=%0d want=%0d",
                         cyc_n, bus.retarget_cnt, r.val);
            end
        end
`endif
    end

    initial begin
        rst_n         = 1'b0;
        bus.ena       = 1'b1;
        bus.run       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_sel   = 2'd0;

        // Reset state, cfg_ready follows ena
        cyc(0, 1, 0, 0, 2'd0, 0, "pre", 6'd0);
        cyc(0, 0, 0, 0, 2'd0, 1, "rst_ena0", ex(0, 0, 0, 0, 2'd0));
        cyc(0, 1, 0, 0, 2'd0, 1, "rst_idle", ex(0, 0, 0, 1, 2'd0));
        cyc(1, 1, 1, 0, 2'd0, 1, "idle_run", ex(0, 0, 0, 1, 2'd0));

        // Divide by 2; retarget to sel=1 offered at cnt=3
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 1, (i == 3), 2'd1, 1, "div2", ex(i[0], i[0], 1, 1, 2'd0));
        cyc(1, 1, 1, 0, 2'd0, 1, "pend_a", ex(0, 0, 1, 0, 2'd0));
        cyc(1, 1, 1, 0, 2'd0, 1, "pend_a_bnd", ex(1, 1, 1, 0, 2'd0));

        // Divide by 4, then freeze with ena low at cnt=7 (offer ignored while frozen)
        for (int i = 0; i < 7; i++)
            cyc(1, 1, 1, 0, 2'd0, 1, "div4", ex(i[1], (i == 3), 1, 1, 2'd1));
        for (int i = 0; i < 5; i++)
            cyc(1, 0, 1, (i == 1), 2'd3, 1, "freeze", ex(1, 0, 1, 0, 2'd1));
        cyc(1, 1, 1, 0, 2'd0, 1, "thaw", ex(1, 1, 1, 1, 2'd1));

        // Retarget /4 -> /16 at a period start; old period finishes first
        cyc(1, 1, 1, 1, 2'd3, 1, "offer3", ex(0, 0, 1, 1, 2'd1));
        cyc(1, 1, 1, 0, 2'd0, 1, "pend_b0", ex(0, 0, 1, 0, 2'd1));
        cyc(1, 1, 1, 0, 2'd0, 1, "pend_b1", ex(1, 0, 1, 0, 2'd1));
        cyc(1, 1, 1, 0, 2'd0, 1, "pend_b2", ex(1, 1, 1, 0, 2'd1));
        for (int i = 0; i < 16; i++)
            cyc(1, 1, 1, 0, 2'd0, 1, "div16", ex((i >= 8), (i == 15), 1, 1, 2'd3));

        // Drop run; run reasserted during STOP is ignored until IDLE
        cyc(1, 1, 0, 0, 2'd0, 1, "run_low", ex(0, 0, 1, 0, 2'd3));
        for (int i = 1; i < 16; i++)
            cyc(1, 1, 1, 0, 2'd0, 1, "stop16", ex((i >= 8), (i == 15), 1, 0, 2'd3));

        // Accept and run in the same IDLE cycle, then drain /8 from cnt=2
        cyc(1, 1, 1, 1, 2'd2, 1, "idle_cfg_run", ex(0, 0, 0, 1, 2'd3));
        for (int i = 0; i < 2; i++)
            cyc(1, 1, 1, 0, 2'd0, 1, "div8", ex(0, 0, 1, 1, 2'd2));
        cyc(1, 1, 0, 0, 2'd0, 1, "drop_run", ex(0, 0, 1, 0, 2'd2));
        for (int i = 3; i < 8; i++)
            cyc(1, 1, 0, 0, 2'd0, 1, "stop8", ex((i >= 4), (i == 7), 1, 0, 2'd2));
        cyc(1, 1, 0, 0, 2'd0, 1, "idle_a", ex(0, 0, 0, 1, 2'd2));
        cyc(1, 1, 0, 0, 2'd0, 1, "idle_b", ex(0, 0, 0, 1, 2'd2));

        // Reset while PEND holds sel=3
        cyc(1, 1, 1, 0, 2'd0, 1, "run2", ex(0, 0, 0, 1, 2'd2));
        cyc(1, 1, 1, 1, 2'd3, 1, "offer_p3", ex(0, 0, 1, 1, 2'd2));
`ifdef CLK_DIV_CTRL_STATS_EN
        rc_exp(8'd2);
`endif
        cyc(0, 1, 1, 0, 2'd0, 0, "pend_rst", 6'd0);
        cyc(1, 1, 0, 0, 2'd0, 1, "after_rst", ex(0, 0, 0, 1, 2'd0));
`ifdef CLK_DIV_CTRL_STATS_EN
        rc_exp(8'd0);
`endif
        cyc(1, 1, 1, 0, 2'd0, 1, "idle_run2", ex(0, 0, 0, 1, 2'd0));
        cyc(1, 1, 1, 0, 2'd0, 1, "r_c0", ex(0, 0, 1, 1, 2'd0));
        cyc(1, 1, 1, 0, 2'd0, 1, "r_c1", ex(1, 1, 1, 1, 2'd0));
        cyc(1, 1, 0, 0, 2'd0, 1, "drop2", ex(0, 0, 1, 0, 2'd0));
        cyc(1, 1, 0, 0, 2'd0, 1, "stop2", ex(1, 1, 1, 0, 2'd0));
        // A discarded pend must not be applied on the way back to IDLE
        cyc(1, 1, 0, 0, 2'd0, 1, "no_pend", ex(0, 0, 0, 1, 2'd0));

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
